// File: rtl/apb_periph_pkg.sv
// Shared APB peripheral constants: timer register offsets, CTRL bit
// positions and the interrupt line the timer drives on the subsystem.
package apb_periph_pkg;

  // Word offsets (byte address bits [7:2]).
  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_VALUE    = 6'h01;
  localparam logic [5:0] ADDR_RELOAD   = 6'h02;
  localparam logic [5:0] ADDR_INTSTAT  = 6'h03;
  localparam logic [5:0] ADDR_PRESCALE = 6'h04;

  // CTRL bit positions, mirrored by the software header.
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_IRQEN_BIT   = 1;
  localparam int CTRL_EXTEN_BIT   = 2;
  localparam int CTRL_ONESHOT_BIT = 3;

  // Bit of apb_interrupt that the timer instance drives.
  localparam int TIMER_IRQ_LINE = 20;

  // Packed so the field order matches the CTRL bit positions above.
  typedef struct packed {
    logic oneshot;
    logic exten;
    logic irqen;
    logic en;
  } timer_ctrl_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector; pulse is one
// clock wide and appears two cycles after the input is first sampled high.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic sync_q1;
  logic sync_q2;
  logic edge_q;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the pre-edge value of its neighbour, forming a real shift chain.
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
      edge_q  <= sync_q2;
    end
  end

  assign pulse = sync_q2 & ~edge_q;

endmodule

// File: rtl/apb_timer.sv
// APB down-counting timer with prescaler, reload, one-shot mode and an
// optional external tick source; zero-wait-state APB slave.
module apb_timer
  import apb_periph_pkg::*;
#(
  parameter int CntWidth = 32,
  parameter int PreWidth = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic [5:0]  PADDR,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        EXTIN,
  output logic        TIMERINT
);

  timer_ctrl_t         ctrl_q, ctrl_d;
  logic [CntWidth-1:0] value_q, value_d;
  logic [CntWidth-1:0] reload_q;
  logic [PreWidth-1:0] prescale_q;
  logic [PreWidth-1:0] pre_cnt_q, pre_cnt_d;
  logic                intstat_q, intstat_d;
  logic                timerint_q;

  logic access;
  logic addr_bad;
  logic wr_en;
  logic ext_pulse;
  logic src_pulse;
  logic tick;
  logic expire;
  logic unused_pwdata;

  sync_edge_det u_sync_edge_det (
    .clk      (PCLK),
    .rst      (PRESET),
    .async_in (EXTIN),
    .pulse    (ext_pulse)
  );

  assign access   = PSEL & PENABLE;
  assign addr_bad = PADDR > ADDR_PRESCALE;
  assign PREADY   = 1'b1;
  assign wr_en    = access & PWRITE & PREADY & ~addr_bad;
  // Error response is suppressed while reset holds the block idle.
  assign PSLVERR  = access & addr_bad & ~PRESET;

  // Only the low bits of PWDATA reach any register; fold the rest away.
  assign unused_pwdata = ^PWDATA;

  // Tick source and expiry: a tick is the source pulse that completes a
  // prescaler period; expiry is a tick arriving while VALUE is already 0.
  assign src_pulse = ctrl_q.en & (ctrl_q.exten ? ext_pulse : 1'b1);
  assign tick      = src_pulse & (pre_cnt_q == prescale_q);
  assign expire    = tick & (value_q == '0);

  // Read mux: addressed register zero-extended during a read access phase.
  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE) begin
      case (PADDR)
        ADDR_CTRL:     PRDATA = 32'(ctrl_q);
        ADDR_VALUE:    PRDATA = 32'(value_q);
        ADDR_RELOAD:   PRDATA = 32'(reload_q);
        ADDR_INTSTAT:  PRDATA = 32'(intstat_q);
        ADDR_PRESCALE: PRDATA = 32'(prescale_q);
        default:       PRDATA = '0;
      endcase
    end
  end

  // Counting behaviour first, then APB writes layered on top so a write
  // overrides the counter, except that a new expiry beats an INTSTAT clear.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can leave one unassigned and infer a latch.
    ctrl_d    = ctrl_q;
    value_d   = value_q;
    intstat_d = intstat_q;
    pre_cnt_d = pre_cnt_q;

    if (!ctrl_q.en || tick) begin
      pre_cnt_d = '0;
    end else if (src_pulse) begin
      pre_cnt_d = pre_cnt_q + PreWidth'(1);
    end

    if (tick) begin
      if (!expire) begin
        value_d = value_q - CntWidth'(1);
      end else begin
        intstat_d = 1'b1;
        if (ctrl_q.oneshot) begin
          ctrl_d.en = 1'b0;
        end else begin
          value_d = reload_q;
        end
      end
    end

    if (wr_en) begin
      case (PADDR)
        ADDR_CTRL:    ctrl_d  = timer_ctrl_t'(PWDATA[3:0]);
        ADDR_VALUE:   value_d = PWDATA[CntWidth-1:0];
        ADDR_INTSTAT: if (PWDATA[0] && !expire) intstat_d = 1'b0;
        default:      ;
      endcase
    end
  end

  // State registers; reset clears everything so a count in flight is lost.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_q     <= '0;
      value_q    <= '0;
      reload_q   <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      intstat_q  <= 1'b0;
      timerint_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      value_q    <= value_d;
      pre_cnt_q  <= pre_cnt_d;
      intstat_q  <= intstat_d;
      timerint_q <= intstat_q & ctrl_q.irqen;
      if (wr_en && PADDR == ADDR_RELOAD)   reload_q   <= PWDATA[CntWidth-1:0];
      if (wr_en && PADDR == ADDR_PRESCALE) prescale_q <= PWDATA[PreWidth-1:0];
    end
  end

  assign TIMERINT = timerint_q;

endmodule
